// File: rtl/stage_ex_pkg.sv
// stage_ex_pkg: opcodes, memory-op codes and the EX2MEM bus layout shared by
// the execute stage and the extract side in stage_mem.
package stage_ex_pkg;
    localparam int ALU_OPT_WIDTH = 5;
    localparam int MEM_OPT_WIDTH = 2;
    localparam int REGADDR_WIDTH = 5;

    localparam logic [ALU_OPT_WIDTH-1:0] ALU_ADD  = 5'd0;
    localparam logic [ALU_OPT_WIDTH-1:0] ALU_SUB  = 5'd1;
    localparam logic [ALU_OPT_WIDTH-1:0] ALU_AND  = 5'd2;
    localparam logic [ALU_OPT_WIDTH-1:0] ALU_OR   = 5'd3;
    localparam logic [ALU_OPT_WIDTH-1:0] ALU_XOR  = 5'd4;
    localparam logic [ALU_OPT_WIDTH-1:0] ALU_NOR  = 5'd5;
    localparam logic [ALU_OPT_WIDTH-1:0] ALU_SLL  = 5'd6;
    localparam logic [ALU_OPT_WIDTH-1:0] ALU_SRL  = 5'd7;
    localparam logic [ALU_OPT_WIDTH-1:0] ALU_SRA  = 5'd8;
    localparam logic [ALU_OPT_WIDTH-1:0] ALU_SLT  = 5'd9;
    localparam logic [ALU_OPT_WIDTH-1:0] ALU_SLTU = 5'd10;
    localparam logic [ALU_OPT_WIDTH-1:0] ALU_LUI  = 5'd11;
    localparam logic [ALU_OPT_WIDTH-1:0] ALU_MUL  = 5'd12;
    localparam logic [ALU_OPT_WIDTH-1:0] ALU_DIV  = 5'd13;
    localparam logic [ALU_OPT_WIDTH-1:0] ALU_DIVU = 5'd14;
    localparam logic [ALU_OPT_WIDTH-1:0] ALU_REM  = 5'd15;
    localparam logic [ALU_OPT_WIDTH-1:0] ALU_REMU = 5'd16;

    localparam logic [MEM_OPT_WIDTH-1:0] MEM_OPT_NONE  = 2'd0;
    localparam logic [MEM_OPT_WIDTH-1:0] MEM_OPT_READ  = 2'd1;
    localparam logic [MEM_OPT_WIDTH-1:0] MEM_OPT_WRITE = 2'd2;

    typedef struct packed {
        logic [REGADDR_WIDTH-1:0] wb_reg_addr;
        logic [31:0]              alu_result;
        logic [MEM_OPT_WIDTH-1:0] mem_opt;
        logic [31:0]              mem_addr;
    } ex2mem_t;

    localparam int EX2MEM_WIRE_WIDTH = $bits(ex2mem_t);
    localparam int EX2MEM_ADDR_LSB   = 0;
    localparam int EX2MEM_OPT_LSB    = 32;
    localparam int EX2MEM_ALU_LSB    = 32 + MEM_OPT_WIDTH;
    localparam int EX2MEM_WB_LSB     = 64 + MEM_OPT_WIDTH;

    typedef enum logic {ST_IDLE, ST_BUSY} ex_state_e;

    function automatic logic is_muldiv(input logic [ALU_OPT_WIDTH-1:0] op);
        return op inside {ALU_MUL, ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU};
    endfunction
endpackage

// File: rtl/ex_muldiv.sv
// ex_muldiv: iterative shift-add multiplier / restoring divider retiring
// ITER_BITS bits per cycle, with signed magnitude pre/post-processing.
module ex_muldiv
    import stage_ex_pkg::*;
#(
    parameter int ITER_BITS = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_start,
    input  logic [ALU_OPT_WIDTH-1:0] i_op,
    input  logic [31:0]              i_a,
    input  logic [31:0]              i_b,
    output logic                     o_done,
    output logic [31:0]              o_result
);
    localparam int ITER = 32 / ITER_BITS;
    localparam int CW = $clog2(ITER + 1);

    logic [CW-1:0]            r_cnt;
    logic [ALU_OPT_WIDTH-1:0] r_op;
    logic [31:0]              r_a, r_b, r_acc;
    logic                     r_neg_q, r_neg_r, r_dvz;
    logic                     w_sgn;
    logic [31:0]              w_a, w_b, w_acc;
    logic [32:0]              w_sh;

    assign w_sgn = i_op == ALU_DIV || i_op == ALU_REM;

    // r_a: multiplier / dividend shifting into quotient; r_b: multiplicand / divisor;
    // r_acc: product / partial remainder
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt   <= '0;
            r_op    <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_acc   <= '0;
            r_neg_q <= 1'b0;
            r_neg_r <= 1'b0;
            r_dvz   <= 1'b0;
        end else if (i_start) begin
            r_cnt   <= CW'(ITER);
            r_op    <= i_op;
            r_a     <= (w_sgn && i_a[31]) ? -i_a : i_a;
            r_b     <= (w_sgn && i_b[31]) ? -i_b : i_b;
            r_acc   <= '0;
            r_neg_q <= w_sgn && (i_a[31] ^ i_b[31]);
            r_neg_r <= w_sgn && i_a[31];
            r_dvz   <= i_b == 32'd0;
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - 1'b1;
            r_a   <= w_a;
            r_b   <= w_b;
            r_acc <= w_acc;
        end
    end

    always_comb begin
        w_a   = r_a;
        w_b   = r_b;
        w_acc = r_acc;
        w_sh  = '0;
        for (int i = 0; i < ITER_BITS; i++) begin
            if (r_op == ALU_MUL) begin
                w_acc = w_acc + (w_a[0] ? w_b : 32'd0);
                w_b   = w_b << 1;
                w_a   = w_a >> 1;
            end else begin
                w_sh  = {w_acc, w_a[31]};
                w_a   = {w_a[30:0], w_sh >= {1'b0, w_b}};
                w_acc = (w_sh >= {1'b0, w_b}) ? 32'(w_sh - {1'b0, w_b}) : w_sh[31:0];
            end
        end
    end

    // Result reflects the final iteration so the top can register it on the done edge
    assign o_done   = r_cnt == CW'(1);
    assign o_result = r_op == ALU_MUL ? w_acc :
                      (r_op == ALU_DIV || r_op == ALU_DIVU) ? (r_dvz ? '1 : r_neg_q ? -w_a : w_a) :
                      r_neg_r ? -w_acc : w_acc;
endmodule

// File: rtl/stage_ex.sv
// stage_ex: execute stage; single-cycle inline ALU plus an iterative mul/div
// unit that holds the pipeline through set_stall, driving the EX2MEM bus.
module stage_ex
    import stage_ex_pkg::*;
#(
    parameter int ITER_BITS = 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         stall,
    input  logic [ALU_OPT_WIDTH-1:0]     alu_opt,
    input  logic [31:0]                  operand_a,
    input  logic [31:0]                  operand_b,
    input  logic [31:0]                  mem_offset,
    input  logic [MEM_OPT_WIDTH-1:0]     mem_opt_id2ex,
    input  logic [REGADDR_WIDTH-1:0]     wb_reg_addr_id2ex,
    output logic [EX2MEM_WIRE_WIDTH-1:0] interstage_ex2mem,
    output logic                         set_stall
);
    ex_state_e                r_state, w_state;
    ex2mem_t                  r_out;
    logic [REGADDR_WIDTH-1:0] r_wb_md;
    logic                     r_set_stall;
    logic                     w_accept, w_start, w_done;
    logic [31:0]              w_alu, w_md_result;

    ex_muldiv #(.ITER_BITS(ITER_BITS)) u_muldiv (
        .clk      (clk),
        .rst      (rst),
        .i_start  (w_start),
        .i_op     (alu_opt),
        .i_a      (operand_a),
        .i_b      (operand_b),
        .o_done   (w_done),
        .o_result (w_md_result)
    );

    always_comb begin
        w_alu = '0;
        case (alu_opt)
            ALU_ADD:  w_alu = operand_a + operand_b;
            ALU_SUB:  w_alu = operand_a - operand_b;
            ALU_AND:  w_alu = operand_a & operand_b;
            ALU_OR:   w_alu = operand_a | operand_b;
            ALU_XOR:  w_alu = operand_a ^ operand_b;
            ALU_NOR:  w_alu = ~(operand_a | operand_b);
            ALU_SLL:  w_alu = operand_a << operand_b[4:0];
            ALU_SRL:  w_alu = operand_a >> operand_b[4:0];
            ALU_SRA:  w_alu = $signed(operand_a) >>> operand_b[4:0];
            ALU_SLT:  w_alu = {31'd0, $signed(operand_a) < $signed(operand_b)};
            ALU_SLTU: w_alu = {31'd0, operand_a < operand_b};
            ALU_LUI:  w_alu = operand_b << 16;
            default:  w_alu = '0;
        endcase
    end

    always_comb begin
        w_state  = r_state;
        w_accept = r_state == ST_IDLE && !stall;
        w_start  = w_accept && is_muldiv(alu_opt);
        if (w_start)
            w_state = ST_BUSY;
        else if (r_state == ST_BUSY && w_done)
            w_state = ST_IDLE;
    end

    // Starting a mul/div leaves EX2MEM untouched; the result lands on the done edge
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_set_stall <= 1'b0;
            r_wb_md     <= '0;
            r_out       <= '0;
        end else begin
            r_state     <= w_state;
            r_set_stall <= w_state == ST_BUSY;
            if (w_start)
                r_wb_md <= wb_reg_addr_id2ex;
            if (w_accept && !w_start)
                r_out <= '{wb_reg_addr: wb_reg_addr_id2ex,
                           alu_result:  mem_opt_id2ex != MEM_OPT_NONE ? operand_b : w_alu,
                           mem_opt:     mem_opt_id2ex,
                           mem_addr:    operand_a + mem_offset};
            else if (r_state == ST_BUSY && w_done)
                r_out <= '{wb_reg_addr: r_wb_md, alu_result: w_md_result,
                           mem_opt: MEM_OPT_NONE, mem_addr: 32'd0};
        end
    end

    assign interstage_ex2mem = r_out;
    assign set_stall         = r_set_stall;
endmodule

// File: tb/tb_stage_ex.sv
// tb_stage_ex: two stage_ex instances (ITER_BITS 1 and 4) on shared stimulus,
// checked every cycle against a behavioural model plus directed literal cases.
module tb_stage_ex;
    import stage_ex_pkg::*;

    logic                         clk = 1'b0;
    logic                         rst;
    logic                         stall;
    logic [ALU_OPT_WIDTH-1:0]     alu_opt;
    logic [31:0]                  operand_a, operand_b, mem_offset;
    logic [MEM_OPT_WIDTH-1:0]     mem_opt_id2ex;
    logic [REGADDR_WIDTH-1:0]     wb_reg_addr_id2ex;
    logic [EX2MEM_WIRE_WIDTH-1:0] out0, out1;
    logic                         st0, st1;

    int n_checks = 0;
    int n_err    = 0;
    logic en = 1'b0;

    logic [EX2MEM_WIRE_WIDTH-1:0] exp_out [2];
    int                           busy    [2];
    logic [REGADDR_WIDTH-1:0]     pwb     [2];
    logic [31:0]                  pres    [2];

    always #5 clk = ~clk;

    stage_ex #(.ITER_BITS(1)) dut0 (
        .clk(clk), .rst(rst), .stall(stall), .alu_opt(alu_opt),
        .operand_a(operand_a), .operand_b(operand_b), .mem_offset(mem_offset),
        .mem_opt_id2ex(mem_opt_id2ex), .wb_reg_addr_id2ex(wb_reg_addr_id2ex),
        .interstage_ex2mem(out0), .set_stall(st0)
    );

    stage_ex #(.ITER_BITS(4)) dut1 (
        .clk(clk), .rst(rst), .stall(stall), .alu_opt(alu_opt),
        .operand_a(operand_a), .operand_b(operand_b), .mem_offset(mem_offset),
        .mem_opt_id2ex(mem_opt_id2ex), .wb_reg_addr_id2ex(wb_reg_addr_id2ex),
        .interstage_ex2mem(out1), .set_stall(st1)
    );

    function automatic logic [31:0] alu_of(input logic [EX2MEM_WIRE_WIDTH-1:0] v);
        return v[EX2MEM_ALU_LSB +: 32];
    endfunction

    function automatic logic [31:0] addr_of(input logic [EX2MEM_WIRE_WIDTH-1:0] v);
        return v[EX2MEM_ADDR_LSB +: 32];
    endfunction

    function automatic logic [REGADDR_WIDTH-1:0] wb_of(input logic [EX2MEM_WIRE_WIDTH-1:0] v);
        return v[EX2MEM_WB_LSB +: REGADDR_WIDTH];
    endfunction

    function automatic logic [MEM_OPT_WIDTH-1:0] mo_of(input logic [EX2MEM_WIRE_WIDTH-1:0] v);
        return v[EX2MEM_OPT_LSB +: MEM_OPT_WIDTH];
    endfunction

    function automatic logic md_op(input logic [ALU_OPT_WIDTH-1:0] op);
        return op == ALU_MUL || op == ALU_DIV || op == ALU_DIVU || op == ALU_REM || op == ALU_REMU;
    endfunction

    function automatic logic [31:0] ref_alu(input logic [ALU_OPT_WIDTH-1:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] p;
        logic        ovf;
        p   = {32'd0, a} * {32'd0, b};
        ovf = a == 32'h8000_0000 && b == 32'hFFFF_FFFF;
        case (op)
            ALU_ADD:  return a + b;
            ALU_SUB:  return a - b;
            ALU_AND:  return a & b;
            ALU_OR:   return a | b;
            ALU_XOR:  return a ^ b;
            ALU_NOR:  return ~(a | b);
            ALU_SLL:  return a << b[4:0];
            ALU_SRL:  return a >> b[4:0];
            ALU_SRA:  return $signed(a) >>> b[4:0];
            ALU_SLT:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            ALU_SLTU: return (a < b) ? 32'd1 : 32'd0;
            ALU_LUI:  return {b[15:0], 16'd0};
            ALU_MUL:  return p[31:0];
            ALU_DIVU: return b == 0 ? 32'hFFFF_FFFF : a / b;
            ALU_REMU: return b == 0 ? a : a % b;
            ALU_DIV:  return b == 0 ? 32'hFFFF_FFFF : ovf ? 32'h8000_0000 : 32'($signed(a) / $signed(b));
            ALU_REM:  return b == 0 ? a : ovf ? 32'd0 : 32'($signed(a) % $signed(b));
            default:  return 32'd0;
        endcase
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            exp_out[k] = '0;
            busy[k]    = 0;
        end
    endtask

    // Called once per rising edge with the inputs that were presented to it
    task automatic model_step();
        for (int k = 0; k < 2; k++) begin
            if (busy[k] > 0) begin
                busy[k]--;
                if (busy[k] == 0)
                    exp_out[k] = {pwb[k], pres[k], MEM_OPT_NONE, 32'd0};
            end else if (!stall) begin
                if (md_op(alu_opt)) begin
                    busy[k] = k == 0 ? 32 : 8;
                    pwb[k]  = wb_reg_addr_id2ex;
                    pres[k] = ref_alu(alu_opt, operand_a, operand_b);
                end else begin
                    exp_out[k] = {wb_reg_addr_id2ex,
                                  mem_opt_id2ex != MEM_OPT_NONE ? operand_b : ref_alu(alu_opt, operand_a, operand_b),
                                  mem_opt_id2ex, 32'(operand_a + mem_offset)};
                end
            end
        end
    endtask

    task automatic chk(input string name, input logic [95:0] act, input logic [95:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, expv);
        end
    endtask

    always @(negedge clk) begin
        if (en && !rst) begin
            chk("ex2mem0", out0, exp_out[0]);
            chk("stall0", st0, busy[0] > 0);
            chk("ex2mem1", out1, exp_out[1]);
            chk("stall1", st1, busy[1] > 0);
        end
    end

    task automatic drive(input logic [ALU_OPT_WIDTH-1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] off, input logic [MEM_OPT_WIDTH-1:0] mo,
                         input logic [REGADDR_WIDTH-1:0] wb, input logic st);
        alu_opt           = op;
        operand_a         = a;
        operand_b         = b;
        mem_offset        = off;
        mem_opt_id2ex     = mo;
        wb_reg_addr_id2ex = wb;
        stall             = st;
    endtask

    task automatic bubble();
        drive(ALU_ADD, 32'd0, 32'd0, 32'd0, MEM_OPT_NONE, '0, 1'b0);
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic run_md(input string name, input logic [ALU_OPT_WIDTH-1:0] op,
                          input logic [31:0] a, input logic [31:0] b, input logic [31:0] expv);
        int          cnt0, cnt1;
        logic        seen0, seen1;
        logic [31:0] res0, res1;
        logic [REGADDR_WIDTH-1:0] wbr;
        drive(op, a, b, 32'd0, MEM_OPT_NONE, 5'd9, 1'b0);
        tick();
        bubble();
        cnt0  = st0 ? 1 : 0;
        cnt1  = st1 ? 1 : 0;
        seen0 = 1'b0;
        seen1 = 1'b0;
        res0  = '0;
        res1  = '0;
        wbr   = '0;
        for (int i = 0; i < 100 && !(seen0 && seen1); i++) begin
            tick();
            if (!seen0) begin
                if (st0) cnt0++;
                else begin
                    seen0 = 1'b1;
                    res0  = alu_of(out0);
                    wbr   = wb_of(out0);
                end
            end
            if (!seen1) begin
                if (st1) cnt1++;
                else begin
                    seen1 = 1'b1;
                    res1  = alu_of(out1);
                end
            end
        end
        chk("md_done", {seen0, seen1}, 2'b11);
        chk("md_stall_cycles_iter1", cnt0, 32);
        chk("md_stall_cycles_iter4", cnt1, 8);
        chk({name, "_iter1"}, res0, expv);
        chk({name, "_iter4"}, res1, expv);
        chk("md_wb", wbr, 5'd9);
    endtask

    function automatic logic [31:0] rnd32();
        case ($urandom_range(0, 5))
            0:       return 32'd0;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return $urandom_range(0, 20);
            default: return $urandom;
        endcase
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        logic [ALU_OPT_WIDTH-1:0] op;
        logic [MEM_OPT_WIDTH-1:0] mo;
        rst = 1'b1;
        bubble();
        model_reset();
        repeat (3) @(negedge clk);
        chk("reset_out0", out0, '0);
        chk("reset_out1", out1, '0);
        chk("reset_stall", {st0, st1}, 2'b00);
        rst = 1'b0;
        en  = 1'b1;

        drive(ALU_ADD, 32'hFFFF_FFFF, 32'd1, 32'd0, MEM_OPT_NONE, 5'd5, 1'b0);
        tick();
        chk("add_wrap", alu_of(out0), 32'd0);
        chk("add_wb", wb_of(out0), 5'd5);
        chk("add_memopt", mo_of(out0), MEM_OPT_NONE);

        drive(ALU_SRA, 32'h8000_0000, 32'd4, 32'd0, MEM_OPT_NONE, 5'd6, 1'b0);
        tick();
        chk("sra", alu_of(out0), 32'hF800_0000);

        drive(ALU_ADD, 32'h0000_1000, 32'hDEAD_BEEF, 32'hFFFF_FFFC, MEM_OPT_WRITE, 5'd0, 1'b0);
        tick();
        chk("store_addr", addr_of(out0), 32'h0000_0FFC);
        chk("store_data", alu_of(out0), 32'hDEAD_BEEF);

        drive(ALU_ADD, 32'd3, 32'd4, 32'd0, MEM_OPT_NONE, 5'd7, 1'b1);
        repeat (3) tick();
        chk("stall_hold_data", alu_of(out1), 32'hDEAD_BEEF);
        chk("stall_hold_addr", addr_of(out0), 32'h0000_0FFC);
        stall = 1'b0;
        tick();
        chk("stall_release", alu_of(out0), 32'd7);
        chk("stall_release_wb", wb_of(out1), 5'd7);

        run_md("mul", ALU_MUL, 32'h0001_0000, 32'h0001_0000, 32'd0);
        run_md("div_neg", ALU_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD);
        run_md("rem_neg", ALU_REM, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF);
        run_md("divu_zero", ALU_DIVU, 32'd5, 32'd0, 32'hFFFF_FFFF);
        run_md("remu_zero", ALU_REMU, 32'd5, 32'd0, 32'd5);
        run_md("div_ovf", ALU_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);

        drive(ALU_DIVU, 32'd100, 32'd7, 32'd0, MEM_OPT_NONE, 5'd3, 1'b0);
        tick();
        bubble();
        repeat (9) tick();
        #2;
        en  = 1'b0;
        rst = 1'b1;
        #1;
        chk("async_rst_stall", {st0, st1}, 2'b00);
        chk("async_rst_out0", out0, '0);
        chk("async_rst_out1", out1, '0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        en  = 1'b1;
        run_md("divu_after_rst", ALU_DIVU, 32'd100, 32'd7, 32'd14);

        for (int i = 0; i < 600; i++) begin
            op = ALU_OPT_WIDTH'($urandom_range(0, 19));
            mo = (!md_op(op) && $urandom_range(0, 3) == 0) ?
                 ($urandom_range(0, 1) == 1 ? MEM_OPT_WRITE : MEM_OPT_READ) : MEM_OPT_NONE;
            drive(op, rnd32(), rnd32(), rnd32(), mo, REGADDR_WIDTH'($urandom_range(0, 31)),
                  $urandom_range(0, 3) == 0);
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end
endmodule
